// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed N-digit 7-segment display driver. One digit is driven
//   per scan slot: a one-hot digit select plus that digit's decoded segments.
//   New digit values are staged on load and only copied to the display at a
//   frame boundary, so a single frame never mixes old and new digits.
//   Also provides leading-zero blanking, per-digit blink, optional hex glyphs
//   and selectable output polarity.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active low
//   load           1-cycle strobe, captures digits_in into staging
//   digits_in      packed digits, [3:0] = digit 0 (least significant)
//   blank_lz_en    enable leading-zero blanking
//   blink_en       enable blinking of digits selected by blink_mask
//   blink_mask     bit i = 1: digit i blinks
//   seg_out        segments {a,b,c,d,e,f,g}, a = MSB
//   dig_sel        one-hot digit enable
//   frame_tick     high during the last clock of each frame
//   update_pending staging holds a value not yet shown

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50,
  parameter int HEX_EN       = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      blank_lz_en,
  input  logic                      blink_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [6:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_tick,
  output logic                      update_pending
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic          INV        = (ACTIVE_LOW != 0);

  localparam logic [6:0] GLYPH_ZERO = 7'b111_1110;

  logic [PW-1:0]           prescaler, prescaler_n;
  logic [IW-1:0]           index, index_n;
  logic [4*NUM_DIGITS-1:0] display, display_n;
  logic [4*NUM_DIGITS-1:0] staging, staging_n;
  logic                    pending, pending_n;
  logic [BW-1:0]           blink_cnt, blink_cnt_n;
  logic                    blink_phase, blink_phase_n;
  logic                    boundary;

  logic [3:0]              digit_n;
  logic                    lz_blank, blink_blank;
  logic                    all_zero;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    tick_n;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b000_0001;
    case (code)
      4'd0: g = 7'b111_1110;
      4'd1: g = 7'b011_0000;
      4'd2: g = 7'b110_1101;
      4'd3: g = 7'b111_1001;
      4'd4: g = 7'b011_0011;
      4'd5: g = 7'b101_1011;
      4'd6: g = 7'b101_1111;
      4'd7: g = 7'b111_0000;
      4'd8: g = 7'b111_1111;
      4'd9: g = 7'b111_0011;
      default: begin
        if (HEX_EN != 0) begin
          case (code)
            4'd10:   g = 7'b111_0111;
            4'd11:   g = 7'b001_1111;
            4'd12:   g = 7'b100_1110;
            4'd13:   g = 7'b011_1101;
            4'd14:   g = 7'b100_1111;
            default: g = 7'b100_0111;
          endcase
        end else begin
          g = 7'b000_0001;
        end
      end
    endcase
    return g;
  endfunction

  // Next-state logic; the output registers are loaded from the next-state
  // values so they change on the same edge as index/display.
  always_comb begin
    boundary      = (prescaler == PRE_LAST) && (index == IDX_LAST);
    prescaler_n   = (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
    index_n       = index;
    if (prescaler == PRE_LAST)
      index_n = (index == IDX_LAST) ? '0 : index + IW'(1);

    display_n     = (boundary && pending) ? staging : display;
    staging_n     = load ? digits_in : staging;
    // A load on the boundary edge stays pending for the following frame.
    pending_n     = boundary ? load : (pending | load);

    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    if (!blink_en) begin
      blink_cnt_n   = '0;
      blink_phase_n = 1'b0;
    end else if (boundary) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        blink_cnt_n   = blink_cnt + BW'(1);
      end
    end

    // Walk from the top digit down so all_zero means "this digit and every
    // higher digit are zero" when we reach the selected index.
    digit_n  = '0;
    lz_blank = 1'b0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (display_n[4*i +: 4] == 4'd0);
      if (index_n == IW'(i)) begin
        digit_n = display_n[4*i +: 4];
        if (blank_lz_en && (i != 0) && all_zero)
          lz_blank = 1'b1;
      end
    end

    blink_blank = 1'b0;
    sel_n       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_n[i] = (index_n == IW'(i));
      if (sel_n[i] && blink_en && blink_mask[i] && blink_phase_n)
        blink_blank = 1'b1;
    end

    seg_n  = (lz_blank || blink_blank) ? 7'b000_0000 : decode(digit_n);
    tick_n = (prescaler_n == PRE_LAST) && (index_n == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler      <= '0;
      index          <= '0;
      display        <= '0;
      staging        <= '0;
      pending        <= 1'b0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b0;
      seg_out        <= INV ? ~GLYPH_ZERO : GLYPH_ZERO;
      dig_sel        <= INV ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
      frame_tick     <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      prescaler      <= prescaler_n;
      index          <= index_n;
      display        <= display_n;
      staging        <= staging_n;
      pending        <= pending_n;
      blink_cnt      <= blink_cnt_n;
      blink_phase    <= blink_phase_n;
      seg_out        <= INV ? ~seg_n : seg_n;
      dig_sel        <= INV ? ~sel_n : sel_n;
      frame_tick     <= tick_n;
      update_pending <= pending_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b111_1110;
  localparam logic [6:0] G1 = 7'b011_0000;
  localparam logic [6:0] G2 = 7'b110_1101;
  localparam logic [6:0] G3 = 7'b111_1001;
  localparam logic [6:0] G4 = 7'b011_0011;
  localparam logic [6:0] G5 = 7'b101_1011;
  localparam logic [6:0] G9 = 7'b111_0011;
  localparam logic [6:0] GDASH = 7'b000_0001;
  localparam logic [6:0] GHEXA = 7'b111_0111;
  localparam logic [6:0] GOFF = 7'b000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] digits_in = '0;
  logic        blank_lz_en = 1'b0;
  logic        blink_en = 1'b0;
  logic [2:0]  blink_mask = '0;

  logic [6:0]  seg_out, seg_out_h;
  logic [2:0]  dig_sel, dig_sel_h;
  logic        frame_tick, frame_tick_h;
  logic        update_pending, update_pending_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(0), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_lz_en(blank_lz_en), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_tick(frame_tick),
    .update_pending(update_pending)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(1), .ACTIVE_LOW(1)
  ) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_lz_en(blank_lz_en), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg_out(seg_out_h), .dig_sel(dig_sel_h), .frame_tick(frame_tick_h),
    .update_pending(update_pending_h)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance until the boundary cycle (frame_tick high), bounded.
  task automatic wait_boundary(input string tag);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_boundary"}, {31'd0, frame_tick}, 32'd1);
  endtask

  // Called at the first clock of a frame; checks all 12 clocks and ends at
  // the first clock of the next frame.
  task automatic check_frame(input string tag, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] exp_seg [3];
    logic [2:0] exp_sel;
    int slot;
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    for (int k = 0; k < 12; k++) begin
      slot = k / 4;
      exp_sel = 3'b001 << slot;
      chk($sformatf("%s_sel_k%0d", tag, k), {29'd0, dig_sel}, {29'd0, exp_sel});
      chk($sformatf("%s_seg_k%0d", tag, k), {25'd0, seg_out}, {25'd0, exp_seg[slot]});
      chk($sformatf("%s_tick_k%0d", tag, k), {31'd0, frame_tick}, {31'd0, (k == 11)});
      tick();
    end
  endtask

  task automatic apply(input logic [11:0] value, input string tag);
    load = 1'b1;
    digits_in = value;
    tick();
    load = 1'b0;
    wait_boundary(tag);
    tick();
  endtask

  initial begin
    // 1: reset, then reset again mid-frame
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_sel", {29'd0, dig_sel}, 32'b001);
    chk("rst_seg", {25'd0, seg_out}, {25'd0, G0});
    chk("rst_pend", {31'd0, update_pending}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_sel_al", {29'd0, dig_sel_h}, 32'b110);
    chk("rst_seg_al", {25'd0, seg_out_h}, {25'd0, GDASH});
    rst_n = 1'b1;
    load = 1'b1;
    digits_in = 12'h987;
    tick();
    load = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rst2_sel", {29'd0, dig_sel}, 32'b001);
    chk("rst2_seg", {25'd0, seg_out}, {25'd0, G0});
    chk("rst2_pend", {31'd0, update_pending}, 32'd0);
    chk("rst2_tick", {31'd0, frame_tick}, 32'd0);
    rst_n = 1'b1;

    // 2: load 345 mid-frame; pending until the boundary; a frame of old zeros
    repeat (5) tick();
    load = 1'b1;
    digits_in = 12'h345;
    tick();
    load = 1'b0;
    chk("t2_pend_set", {31'd0, update_pending}, 32'd1);
    wait_boundary("t2");
    chk("t2_pend_bnd", {31'd0, update_pending}, 32'd1);
    chk("t2_old_seg", {25'd0, seg_out}, {25'd0, G0});
    tick();
    chk("t2_pend_clr", {31'd0, update_pending}, 32'd0);
    check_frame("t2_f0", G5, G4, G3);
    check_frame("t2_f1", G5, G4, G3);

    // 3: leading-zero blanking
    blank_lz_en = 1'b1;
    apply(12'h005, "t3a");
    check_frame("t3_005", G5, GOFF, GOFF);
    apply(12'h000, "t3b");
    check_frame("t3_000", G0, GOFF, GOFF);
    apply(12'h050, "t3c");
    check_frame("t3_050", G0, G5, GOFF);
    blank_lz_en = 1'b0;

    // 4: blink digit 2, half-period 2 frames
    apply(12'h912, "t4");
    blink_mask = 3'b100;
    blink_en = 1'b1;
    check_frame("t4_f0", G2, G1, G9);
    check_frame("t4_f1", G2, G1, G9);
    check_frame("t4_f2", G2, G1, GOFF);
    check_frame("t4_f3", G2, G1, GOFF);
    blink_en = 1'b0;
    check_frame("t4_f4", G2, G1, G9);
    check_frame("t4_f5", G2, G1, G9);
    check_frame("t4_f6", G2, G1, G9);
    blink_mask = 3'b000;

    // 5: last load wins; load on the boundary cycle is held for next frame
    load = 1'b1;
    digits_in = 12'h111;
    tick();
    digits_in = 12'h222;
    tick();
    load = 1'b0;
    wait_boundary("t5");
    chk("t5_pend_bnd", {31'd0, update_pending}, 32'd1);
    load = 1'b1;
    digits_in = 12'h333;
    tick();
    load = 1'b0;
    chk("t5_pend_kept", {31'd0, update_pending}, 32'd1);
    check_frame("t5_222", G2, G2, G2);
    chk("t5_pend_clr", {31'd0, update_pending}, 32'd0);
    check_frame("t5_333", G3, G3, G3);

    // 6: code A, dash vs hex glyph, active-low outputs
    apply(12'h00A, "t6");
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) begin
        chk($sformatf("t6_seg_k%0d", k), {25'd0, seg_out},
            {25'd0, (k == 0) ? GDASH : G0});
        chk($sformatf("t6_seg_al_k%0d", k), {25'd0, seg_out_h},
            {25'd0, (k == 0) ? ~GHEXA : ~G0});
        chk($sformatf("t6_sel_al_k%0d", k), {29'd0, dig_sel_h},
            {29'd0, ~(3'b001 << (k / 4))});
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
